// File: rtl/lsu_pkg.sv
// Shared definitions for the read-modify-write load/store unit: RV32 funct3
// width codes, FSM state encoding and small address/width decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
  localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
  localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
  localparam logic [2:0] F3_BU = 3'd4;  // LBU
  localparam logic [2:0] F3_HU = 3'd5;  // LHU

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Width codes the unit can execute for the given direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // True when the address is not naturally aligned for the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte offset inside the word, aligned down to the natural access size.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends the addressed byte/half
// of a memory word for loads, and merges store data into the addressed
// lane(s) of the old word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [4:0]            shamt;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] half_mask;

  // Lane selection and load extension.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statements can infer a latch.
    load_data = rdata;
    shamt     = {offset, 3'b000};
    byte_sel  = rdata[{offset, 3'b000} +: 8];
    half_sel  = rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Store merge: replace only the target lane(s) of the old word.
  always_comb begin
    merge_data = wdata;
    byte_mask  = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt;
    half_mask  = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
    case (funct3)
      F3_B: merge_data = (rdata & ~byte_mask) |
                         ({{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << shamt);
      F3_H: merge_data = (rdata & ~half_mask) |
                         ({{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << shamt);
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-wide single-port memory without byte enables.
// Sub-word stores are done as read-modify-write. Loads: IDLE-RD-CAP-DONE,
// SW: IDLE-WR-DONE, SB/SH: IDLE-RD-CAP-WR-DONE, faults: IDLE-DONE.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses
// fault; without it they are aligned down to their natural size.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  misalign_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic                  req_fault;
  logic                  trap_misalign;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_misalign = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap_misalign = 1'b0;
`endif

  // A request that must complete immediately with an error and no access.
  assign req_fault = !f3_legal(req_we, req_funct3) || trap_misalign;

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .funct3     (f3_q),
    .offset     (lane_offset(f3_q, addr_q[1:0])),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and request handshake.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)                         state_d = DONE;
          else if (req_we && req_funct3 == F3_W) state_d = WR;
          else                                   state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load result and merged store word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          f3_q      <= req_funct3;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          err_q     <= req_fault;
          rsp_rdata <= '0;
        end
        CAP: begin
          if (we_q) wdata_q   <= merge_data;
          else      rsp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = (state_q == DONE);
  assign misalign_err = (state_q == DONE) && err_q;
  assign mem_wen      = (state_q == WR);
  assign mem_addr     = (state_q == IDLE) ? '0 : {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata    = wdata_q;

endmodule
